// File: rtl/bev_pkg.sv
// rtl/bev_pkg.sv - shared enums, recipe/volume tables and record field helpers
package bev_pkg;

    typedef enum logic [1:0] {
        ACT_MAKE   = 2'd0,
        ACT_SUPPLY = 2'd1,
        ACT_CHECK  = 2'd2
    } action_e;

    typedef enum logic [2:0] {
        BLACK_TEA                = 3'd0,
        MILK_TEA                 = 3'd1,
        EXTRA_MILK_TEA           = 3'd2,
        GREEN_TEA                = 3'd3,
        GREEN_MILK_TEA           = 3'd4,
        PINEAPPLE_JUICE          = 3'd5,
        SUPER_PINEAPPLE_TEA      = 3'd6,
        SUPER_PINEAPPLE_MILK_TEA = 3'd7
    } bev_type_e;

    typedef enum logic [1:0] {
        SIZE_L = 2'd0,
        SIZE_M = 2'd1,
        SIZE_S = 2'd2
    } bev_size_e;

    typedef enum logic [1:0] {
        NO_ERR = 2'd0,
        NO_EXP = 2'd1,
        NO_ING = 2'd2,
        ING_OF = 2'd3
    } error_msg_e;

    localparam int DATE_W = 9;
    localparam logic [7:0] VOLQ_L = 8'd240;
    localparam logic [7:0] VOLQ_M = 8'd180;
    localparam logic [7:0] VOLQ_S = 8'd120;

    // Rows packed as nibbles black/green/milk/pineapple, black in the top nibble.
    function automatic logic [2:0] recipe(input logic [2:0] bev, input int ing);
        logic [15:0] row;
        case (bev)
            BLACK_TEA:                row = 16'h4000;
            MILK_TEA:                 row = 16'h3010;
            EXTRA_MILK_TEA:           row = 16'h2020;
            GREEN_TEA:                row = 16'h0400;
            GREEN_MILK_TEA:           row = 16'h0220;
            PINEAPPLE_JUICE:          row = 16'h0004;
            SUPER_PINEAPPLE_TEA:      row = 16'h2002;
            default:                  row = 16'h2011;
        endcase
        if (ing >= 4 || ing < 0) return 3'd0;
        return row[14-4*ing -: 3];
    endfunction

    function automatic logic [7:0] volq(input logic [1:0] size);
        case (size)
            SIZE_L:  return VOLQ_L;
            SIZE_M:  return VOLQ_M;
            SIZE_S:  return VOLQ_S;
            default: return 8'd0;
        endcase
    endfunction

    function automatic int ing_msb(input int i, input int ing_w, input int n_ing);
        return n_ing*ing_w + DATE_W - 1 - i*ing_w;
    endfunction

endpackage

// File: rtl/bev_order_engine_if.sv
// rtl/bev_order_engine_if.sv - command, memory port and result bundle
interface bev_order_engine_if #(
    parameter int N_ING  = 4,
    parameter int ING_W  = 12,
    parameter int ADDR_W = 8
);
    localparam int REC_W = N_ING*ING_W + 9;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_act;
    logic [2:0]             cmd_type;
    logic [1:0]             cmd_size;
    logic [3:0]             cmd_month;
    logic [4:0]             cmd_day;
    logic [ADDR_W-1:0]      cmd_box;
    logic [N_ING*ING_W-1:0] cmd_sup;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_we;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [REC_W-1:0]       mem_req_wdata;
    logic                   mem_rsp_valid;
    logic [REC_W-1:0]       mem_rsp_rdata;

    logic                   out_valid;
    logic [1:0]             err_msg;
    logic                   complete;

    modport slave (
        input  cmd_valid, cmd_act, cmd_type, cmd_size, cmd_month, cmd_day, cmd_box, cmd_sup,
        output cmd_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output out_valid, err_msg, complete
    );

    modport master (
        output cmd_valid, cmd_act, cmd_type, cmd_size, cmd_month, cmd_day, cmd_box, cmd_sup,
        input  cmd_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  out_valid, err_msg, complete
    );
endinterface

// File: rtl/bev_cmd_fifo.sv
// rtl/bev_cmd_fifo.sv - synchronous command FIFO, resets to empty
module bev_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/bev_order_engine.sv
// rtl/bev_order_engine.sv - queued beverage order engine doing read-modify-write of box records
module bev_order_engine
    import bev_pkg::*;
#(
    parameter int N_ING     = 4,
    parameter int ING_W     = 12,
    parameter int ADDR_W    = 8,
    parameter int CMD_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    bev_order_engine_if.slave bus
);
    localparam int SUP_W = N_ING*ING_W;
    localparam int REC_W = SUP_W + DATE_W;
    localparam int CMD_W = 2 + 3 + 2 + 4 + 5 + ADDR_W + SUP_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_EXEC, S_WR_REQ, S_WR_WAIT, S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        act_q, act_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        size_q, size_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        day_q, day_d;
    logic [ADDR_W-1:0] box_q, box_d;
    logic [SUP_W-1:0]  sup_q, sup_d;
    logic [REC_W-1:0]  rec_q, rec_d, wdata_q, wdata_d;
    error_msg_e        err_q, err_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]  fifo_rdata;
    logic [1:0]        f_act;
    logic [2:0]        f_type;
    logic [1:0]        f_size;
    logic [3:0]        f_month;
    logic [4:0]        f_day;
    logic [ADDR_W-1:0] f_box;
    logic [SUP_W-1:0]  f_sup;

    assign bus.cmd_ready = !fifo_full && !rst;
    assign fifo_push     = bus.cmd_valid && bus.cmd_ready;

    bev_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({bus.cmd_act, bus.cmd_type, bus.cmd_size, bus.cmd_month,
                   bus.cmd_day, bus.cmd_box, bus.cmd_sup}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {f_act, f_type, f_size, f_month, f_day, f_box, f_sup} = fifo_rdata;

    logic [SUP_W-1:0] make_ing, sup_ing;
    logic [N_ING-1:0] short_v, of_v;
    logic             expired;

    // Per-ingredient consumption and saturating refill; sums carry one extra bit.
    for (genvar gi = 0; gi < N_ING; gi++) begin : g_ing
        localparam int RMSB = ing_msb(gi, ING_W, N_ING);
        localparam int SMSB = SUP_W - 1 - gi*ING_W;
        logic [ING_W-1:0] rec_v, need_v, sup_v;
        logic [ING_W:0]   sum_v;
        assign rec_v  = rec_q[RMSB -: ING_W];
        assign need_v = ING_W'(recipe(type_q, gi)) * ING_W'(volq(size_q));
        assign sup_v  = sup_q[SMSB -: ING_W];
        assign sum_v  = {1'b0, rec_v} + {1'b0, sup_v};
        assign short_v[gi] = (rec_v < need_v);
        assign of_v[gi]    = sum_v[ING_W];
        assign make_ing[SMSB -: ING_W] = rec_v - need_v;
        assign sup_ing[SMSB -: ING_W]  = of_v[gi] ? {ING_W{1'b1}} : sum_v[ING_W-1:0];
    end

    assign expired = ({month_q, day_q} > rec_q[DATE_W-1:0]);

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        type_d   = type_q;
        size_d   = size_q;
        month_d  = month_q;
        day_d    = day_q;
        box_d    = box_q;
        sup_d    = sup_q;
        rec_d    = rec_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                {act_d, type_d, size_d, month_d, day_d, box_d, sup_d} =
                    {f_act, f_type, f_size, f_month, f_day, f_box, f_sup};
                state_d = S_RD_REQ;
            end
            S_RD_REQ:  if (bus.mem_req_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: if (bus.mem_rsp_valid) begin
                rec_d   = bus.mem_rsp_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                err_d   = NO_ERR;
                state_d = S_RESP;
                case (act_q)
                    ACT_SUPPLY: begin
                        wdata_d = {sup_ing, month_q, day_q};
                        err_d   = (|of_v) ? ING_OF : NO_ERR;
                        state_d = S_WR_REQ;
                    end
                    ACT_MAKE: begin
                        if (expired) begin
                            err_d = NO_EXP;
                        end else if (|short_v) begin
                            err_d = NO_ING;
                        end else begin
                            wdata_d = {make_ing, rec_q[DATE_W-1:0]};
                            state_d = S_WR_REQ;
                        end
                    end
                    default: err_d = expired ? NO_EXP : NO_ERR;
                endcase
            end
            S_WR_REQ:  if (bus.mem_req_ready) state_d = S_WR_WAIT;
            S_WR_WAIT: if (bus.mem_rsp_valid) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            type_q  <= '0;
            size_q  <= '0;
            month_q <= '0;
            day_q   <= '0;
            box_q   <= '0;
            sup_q   <= '0;
            rec_q   <= '0;
            wdata_q <= '0;
            err_q   <= NO_ERR;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            type_q  <= type_d;
            size_q  <= size_d;
            month_q <= month_d;
            day_q   <= day_d;
            box_q   <= box_d;
            sup_q   <= sup_d;
            rec_q   <= rec_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_req_valid = !rst && (state_q == S_RD_REQ || state_q == S_WR_REQ);
    assign bus.mem_req_we    = (state_q == S_WR_REQ);
    assign bus.mem_req_addr  = box_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.out_valid     = !rst && (state_q == S_RESP);
    assign bus.err_msg       = bus.out_valid ? err_q : NO_ERR;
    assign bus.complete      = bus.out_valid && (err_q == NO_ERR);
endmodule

// File: tb/tb_bev_order_engine.sv
// tb/tb_bev_order_engine.sv - directed scoreboard bench for bev_order_engine
module tb_bev_order_engine;
    import bev_pkg::*;

    localparam int N_ING = 4, ING_W = 12, ADDR_W = 8, CMD_DEPTH = 2;
    localparam int REC_W = N_ING*ING_W + 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bev_order_engine_if #(.N_ING(N_ING), .ING_W(ING_W), .ADDR_W(ADDR_W)) bus ();

    bev_order_engine #(.N_ING(N_ING), .ING_W(ING_W), .ADDR_W(ADDR_W), .CMD_DEPTH(CMD_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [REC_W-1:0]        mem_img [256];
    logic                    ready_block = 1'b0;
    logic                    rsp_hold = 1'b0;
    logic [1:0]              exp_q [$];
    logic [2:0]              got_q [$];
    logic [ADDR_W+REC_W-1:0] wr_log [$];

    function automatic logic [REC_W-1:0] mk(input int b, g, m, p, mo, d);
        return {12'(b), 12'(g), 12'(m), 12'(p), 4'(mo), 5'(d)};
    endfunction

    function automatic logic [N_ING*ING_W-1:0] sup(input int b, g, m, p);
        return {12'(b), 12'(g), 12'(m), 12'(p)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: one-cycle ready, response on the following cycle.
    initial begin
        logic acc, pend, lat_we;
        logic [ADDR_W-1:0] lat_addr;
        logic [REC_W-1:0]  lat_data;
        acc = 0; pend = 0; lat_we = 0; lat_addr = '0; lat_data = '0;
        bus.mem_req_ready = 0;
        bus.mem_rsp_valid = 0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 0;
            bus.mem_rsp_valid = 0;
            if (acc) begin
                acc = 0;
                pend = 1;
                if (lat_we) wr_log.push_back({lat_addr, lat_data});
            end
            if (pend && !rsp_hold) begin
                bus.mem_rsp_valid = 1;
                bus.mem_rsp_rdata = lat_we ? '0 : mem_img[lat_addr];
                pend = 0;
            end else if (!pend && bus.mem_req_valid && !ready_block) begin
                bus.mem_req_ready = 1;
                lat_we   = bus.mem_req_we;
                lat_addr = bus.mem_req_addr;
                lat_data = bus.mem_req_wdata;
                acc = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid) got_q.push_back({bus.err_msg, bus.complete});
        end
    end

    task automatic send_cmd(input logic [1:0] act, input logic [2:0] bt, input logic [1:0] sz,
                            input int mo, input int d, input int box,
                            input logic [N_ING*ING_W-1:0] s, input logic [1:0] exp_err,
                            input bit expect_result);
        int n = 0;
        bus.cmd_valid = 1;
        bus.cmd_act   = act;
        bus.cmd_type  = bt;
        bus.cmd_size  = sz;
        bus.cmd_month = 4'(mo);
        bus.cmd_day   = 5'(d);
        bus.cmd_box   = ADDR_W'(box);
        bus.cmd_sup   = s;
        if (expect_result) exp_q.push_back(exp_err);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle_cmd();
        bus.cmd_valid = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        logic [2:0] got;
        logic [1:0] exp;
        while (got_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_present"}, got_q.size() != 0, 1'b1);
        if (got_q.size() != 0 && exp_q.size() != 0) begin
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            check({tag, "_err"}, got[2:1], exp);
            check({tag, "_complete"}, got[0], exp == 2'd0);
        end
    endtask

    task automatic check_write(input string tag, input int addr, input logic [REC_W-1:0] data);
        logic [ADDR_W+REC_W-1:0] w;
        check({tag, "_wr_present"}, wr_log.size() != 0, 1'b1);
        if (wr_log.size() != 0) begin
            w = wr_log.pop_front();
            check({tag, "_wr_addr"}, w[ADDR_W+REC_W-1:REC_W], ADDR_W'(addr));
            check({tag, "_wr_data"}, w[REC_W-1:0], data);
        end
    endtask

    initial begin
        mem_img[1] = mk(1000, 0, 0, 0, 5, 1);
        mem_img[2] = mk(2000, 2000, 2000, 2000, 6, 1);
        mem_img[3] = mk(0, 50, 500, 0, 12, 31);
        mem_img[4] = mk(100, 7, 20, 5, 1, 1);
        mem_img[5] = mk(0, 0, 0, 0, 0, 0);

        rst = 1;
        bus.cmd_valid = 1;
        bus.cmd_act = ACT_CHECK; bus.cmd_type = '0; bus.cmd_size = '0;
        bus.cmd_month = 4'd1; bus.cmd_day = 5'd1; bus.cmd_box = 8'd1; bus.cmd_sup = '0;
        cycles(3);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_err_msg", bus.err_msg, 2'd0);
        rst = 0;
        idle_cmd();
        cycles(5);
        check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("post_rst_no_req", bus.mem_req_valid, 1'b0);
        check("post_rst_no_result", got_q.size(), 0);

        send_cmd(ACT_MAKE, BLACK_TEA, SIZE_L, 3, 10, 1, '0, NO_ERR, 1);
        idle_cmd();
        wait_result("make_black_L");
        check_write("make_black_L", 1, mk(40, 0, 0, 0, 5, 1));

        send_cmd(ACT_MAKE, MILK_TEA, SIZE_M, 6, 2, 2, '0, NO_EXP, 1);
        idle_cmd();
        wait_result("make_expired");
        check("make_expired_no_write", wr_log.size(), 0);

        send_cmd(ACT_MAKE, GREEN_MILK_TEA, SIZE_S, 1, 1, 3, '0, NO_ING, 1);
        idle_cmd();
        wait_result("make_short");
        check("make_short_no_write", wr_log.size(), 0);

        send_cmd(ACT_SUPPLY, BLACK_TEA, SIZE_L, 12, 31, 4, sup(4000, 0, 10, 3), ING_OF, 1);
        idle_cmd();
        wait_result("supply_sat");
        check_write("supply_sat", 4, mk(4095, 7, 30, 8, 12, 31));

        send_cmd(ACT_CHECK, BLACK_TEA, SIZE_L, 6, 1, 2, '0, NO_ERR, 1);
        idle_cmd();
        wait_result("check_same_day");
        check("check_same_day_no_write", wr_log.size(), 0);

        ready_block = 1;
        send_cmd(ACT_CHECK, BLACK_TEA, SIZE_L, 6, 1, 2, '0, NO_ERR, 1);
        send_cmd(ACT_MAKE, BLACK_TEA, SIZE_S, 1, 1, 1, '0, NO_ERR, 1);
        send_cmd(ACT_CHECK, BLACK_TEA, SIZE_L, 7, 1, 2, '0, NO_EXP, 1);
        idle_cmd();
        check("queue_full_ready", bus.cmd_ready, 1'b0);
        cycles(10);
        check("queue_stalled_ready", bus.cmd_ready, 1'b0);
        check("queue_stalled_no_result", got_q.size(), 0);
        ready_block = 0;
        wait_result("queue_a");
        wait_result("queue_b");
        wait_result("queue_c");
        check_write("queue_b", 1, mk(520, 0, 0, 0, 5, 1));
        check("queue_single_write", wr_log.size(), 0);

        rsp_hold = 1;
        send_cmd(ACT_CHECK, BLACK_TEA, SIZE_L, 1, 1, 1, '0, NO_ERR, 0);
        send_cmd(ACT_CHECK, BLACK_TEA, SIZE_L, 1, 1, 2, '0, NO_ERR, 0);
        idle_cmd();
        begin
            int n = 0;
            while (!bus.mem_req_valid && n < 20) begin @(negedge clk); n++; end
            while (bus.mem_req_valid && n < 40) begin @(negedge clk); n++; end
        end
        rst = 1;
        cycles(1);
        rst = 0;
        check("midrst_req_valid", bus.mem_req_valid, 1'b0);
        rsp_hold = 0;
        cycles(10);
        check("midrst_no_result", got_q.size(), 0);
        check("midrst_fifo_flushed", bus.mem_req_valid, 1'b0);
        check("midrst_no_write", wr_log.size(), 0);

        send_cmd(ACT_SUPPLY, BLACK_TEA, SIZE_L, 2, 3, 5, sup(1, 2, 3, 4), NO_ERR, 1);
        idle_cmd();
        wait_result("post_midrst");
        check_write("post_midrst", 5, mk(1, 2, 3, 4, 2, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
